// File: rtl/fetch_controller_if.sv
// Fetch bundle: instruction-memory read port, pipeline control inputs and IF/ID-facing outputs.
// master is the fetch controller; slave is the memory/pipeline side.
interface fetch_controller_if;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  modport master (
    input  freeze, branch_taken, branch_addr, mem_ready, mem_rdata,
    output mem_req, mem_addr, instr_valid, instr_out, pc_out
  );

  modport slave (
    output freeze, branch_taken, branch_addr, mem_ready, mem_rdata,
    input  mem_req, mem_addr, instr_valid, instr_out, pc_out
  );
endinterface

// File: rtl/fetch_controller.sv
// IF-stage fetch sequencer: owns the PC, keeps one instruction-memory read in flight and
// buffers up to two fetched words for the IF/ID register, redirecting on taken branches.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst_n,
  fetch_controller_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] hold_addr;
  logic [1:0]  count, count_next, count_after_pop;
  logic        rd_ptr;
  logic        wr_idx;
  logic        valid, pop, push;
  logic [31:0] target;
  logic [31:0] fifo_link  [2];
  logic [31:0] fifo_instr [2];

  assign valid           = (count != 2'd0);
  assign pop             = valid & ~bus.freeze & ~bus.branch_taken;
  assign push            = (state == FETCH) & bus.mem_ready & ~bus.branch_taken;
  assign target          = bus.branch_addr & 32'hFFFF_FFFC;
  assign count_after_pop = count - {1'b0, pop};
  assign wr_idx          = rd_ptr ^ count[0];

  // A branch wins over everything: it empties the queue and retargets the PC, and a request
  // still waiting on memory must be drained at its original address before refetching.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    count_next = count_after_pop + {1'b0, push};
    unique case (state)
      IDLE: begin
        if (bus.branch_taken || count_after_pop != 2'd2)
          state_next = FETCH;
      end
      FETCH: begin
        if (bus.branch_taken) begin
          if (!bus.mem_ready)
            state_next = DRAIN;
        end else if (bus.mem_ready && count_after_pop != 2'd0) begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (bus.mem_ready)
          state_next = FETCH;
      end
      default: state_next = IDLE;
    endcase
    if (bus.branch_taken) begin
      pc_next    = target;
      count_next = 2'd0;
    end else if (push) begin
      pc_next = pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      hold_addr <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      count <= count_next;
      if (state == FETCH)
        hold_addr <= pc;
      if (bus.branch_taken)
        rd_ptr <= 1'b0;
      else if (pop)
        rd_ptr <= ~rd_ptr;
    end
  end

  // Queue storage needs no reset: every read of it is qualified by a non-zero count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_link[wr_idx]  <= pc + 32'd4;
      fifo_instr[wr_idx] <= bus.mem_rdata;
    end
  end

  assign bus.mem_req     = (state != IDLE);
  assign bus.mem_addr    = (state == DRAIN) ? hold_addr : pc;
  assign bus.instr_valid = valid;
  assign bus.instr_out   = valid ? fifo_instr[rd_ptr] : 32'd0;
  assign bus.pc_out      = valid ? fifo_link[rd_ptr] : 32'd0;

endmodule

// File: tb/tb_fetch_controller.sv
// Randomised bench for fetch_controller, compared every cycle against a transaction-level
// model made of a word queue and a single outstanding-request record.
module tb_fetch_controller;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;

  fetch_controller_if bus ();

  fetch_controller #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  entry_t      mq[$];
  logic [31:0] mPc;
  logic [31:0] mReqAddr;
  bit          mBusy;
  bit          mDiscard;

  // readyMode: 0 zero-wait, 1 fixed latency, 2 random, 3 never
  int readyMode;
  int latency;
  int freezePct;
  int reqAge;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'hC0DE_0001;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%08h expected=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkState();
    checkOutput("mem_req", {31'd0, bus.mem_req}, {31'd0, mBusy});
    if (mBusy)
      checkOutput("mem_addr", bus.mem_addr, mReqAddr);
    checkOutput("instr_valid", {31'd0, bus.instr_valid}, {31'd0, (mq.size() != 0)});
    if (mq.size() != 0) begin
      checkOutput("instr_out", bus.instr_out, mq[0].instr);
      checkOutput("pc_out", bus.pc_out, mq[0].addr + 32'd4);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mPc      = RESET_PC;
    mReqAddr = RESET_PC;
    mBusy    = 1'b0;
    mDiscard = 1'b0;
    reqAge   = 0;
  endtask

  task automatic applyReset();
    rst_n            = 1'b0;
    bus.freeze       = 1'b0;
    bus.branch_taken = 1'b0;
    bus.mem_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("rst_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    checkOutput("rst_instr_out", bus.instr_out, 32'd0);
    checkOutput("rst_pc_out", bus.pc_out, 32'd0);
    #1 rst_n = 1'b1;
    modelReset();
  endtask

  // One clock: check outputs, drive inputs at the falling edge, advance the model.
  task automatic applyStimulus(input bit doBranch, input logic [31:0] bAddr);
    bit frz;
    bit ready;
    bit pop;
    bit done;
    @(negedge clk);
    checkState();
    frz = ($urandom_range(99) < freezePct);
    case (readyMode)
      0:       ready = 1'b1;
      1:       ready = bus.mem_req && (reqAge == latency - 1);
      2:       ready = ($urandom_range(1) == 1);
      default: ready = 1'b0;
    endcase
    bus.freeze       = frz;
    bus.branch_taken = doBranch;
    bus.branch_addr  = bAddr;
    bus.mem_ready    = ready;
    bus.mem_rdata    = ready ? memWord(bus.mem_addr) : $urandom();
    reqAge           = (bus.mem_req && !ready) ? reqAge + 1 : 0;

    pop  = (mq.size() != 0) && !frz && !doBranch;
    done = mBusy && ready;
    if (doBranch) begin
      mq.delete();
      mPc = bAddr & 32'hFFFF_FFFC;
      if (!mBusy || done) begin
        mBusy    = 1'b1;
        mDiscard = 1'b0;
        mReqAddr = mPc;
      end else begin
        mDiscard = 1'b1;
      end
    end else begin
      if (pop)
        void'(mq.pop_front());
      if (done) begin
        if (!mDiscard) begin
          mq.push_back('{addr: mReqAddr, instr: memWord(mReqAddr)});
          mPc = mReqAddr + 32'd4;
        end
        mBusy    = 1'b0;
        mDiscard = 1'b0;
      end
      if (!mBusy && mq.size() < 2) begin
        mBusy    = 1'b1;
        mReqAddr = mPc;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    readyMode        = 0;
    latency          = 3;
    freezePct        = 0;
    bus.freeze       = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr  = 32'd0;
    bus.mem_ready    = 1'b0;
    bus.mem_rdata    = 32'd0;

    // Zero-wait streaming after reset
    applyReset();
    repeat (12) applyStimulus(1'b0, 32'd0);

    // Three-cycle memory latency
    applyReset();
    readyMode = 1;
    repeat (15) applyStimulus(1'b0, 32'd0);

    // Frozen from reset: two words buffered, then the request drops
    readyMode = 0;
    freezePct = 100;
    applyReset();
    repeat (6) applyStimulus(1'b0, 32'd0);
    checkOutput("full_frozen_req", {31'd0, bus.mem_req}, 32'd0);
    freezePct = 0;
    repeat (6) applyStimulus(1'b0, 32'd0);

    // Branch while the request to 8 is waiting on memory
    applyReset();
    readyMode = 1;
    found     = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      found = bus.mem_req && (bus.mem_addr == 32'h8) && (reqAge == 0);
      applyStimulus(found, 32'h0000_0103);
    end
    checkOutput("branch_at_8", {31'd0, found}, 32'd1);
    repeat (10) applyStimulus(1'b0, 32'd0);

    // Branch coincident with a completion, then with freeze on a full queue (wraps past 0)
    readyMode = 0;
    repeat (3) applyStimulus(1'b0, 32'd0);
    applyStimulus(1'b1, 32'h0000_0200);
    repeat (4) applyStimulus(1'b0, 32'd0);
    freezePct = 100;
    repeat (5) applyStimulus(1'b0, 32'd0);
    applyStimulus(1'b1, 32'hFFFF_FFF6);
    freezePct = 0;
    repeat (8) applyStimulus(1'b0, 32'd0);

    // Random traffic: random ready, freeze and branches
    readyMode = 2;
    freezePct = 30;
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a;
      a = $urandom();
      if ($urandom_range(3) == 0)
        a = 32'hFFFF_FFF0 | {28'd0, a[3:0]};
      applyStimulus($urandom_range(99) < 5, a);
    end

    // Random traffic with a fixed two-cycle memory
    readyMode = 1;
    latency   = 2;
    for (int i = 0; i < 500; i++)
      applyStimulus($urandom_range(99) < 6, $urandom());

    // Asynchronous reset in the middle of a wait-state fetch
    latency   = 3;
    readyMode = 0;
    freezePct = 100;
    applyReset();
    repeat (2) applyStimulus(1'b0, 32'd0);
    readyMode = 3;
    repeat (3) applyStimulus(1'b0, 32'd0);
    checkOutput("pre_reset_req", {31'd0, bus.mem_req}, 32'd1);
    checkOutput("pre_reset_valid", {31'd0, bus.instr_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_req", {31'd0, bus.mem_req}, 32'd0);
    checkOutput("async_valid", {31'd0, bus.instr_valid}, 32'd0);
    readyMode = 0;
    freezePct = 0;
    applyReset();
    repeat (6) applyStimulus(1'b0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
